// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and helpers for the two-way data cache
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2
    } state_e;

    // Ceiling log2 for parameter-time sizing (returns 0 for v <= 1).
    function automatic int log2c(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Replace the bytes of old_w selected by be with those of new_w.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dcache_way.sv
// rtl/dcache_way.sv - one way of the cache: valid, tag and data arrays
//
// Ports:
//   clk, rst              clock, synchronous active-high reset (clears valid bits)
//   idx_i, tag_i          set index and tag of the current access
//   rd_off_i, rdata_o     word offset read port (combinational)
//   hit_o, valid_o        tag match on a valid line / valid bit of the set
//   wr_en_i, wr_off_i,
//   wdata_i, wbe_i        byte-enabled word write into set idx_i
//   inval_i               clear valid of set idx_i
//   fill_i                load tag_i and set valid of set idx_i
module dcache_way
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int IDX_BITS = 4,
    parameter int OFF_BITS = 2,
    parameter int TAG_BITS = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] idx_i,
    input  logic [TAG_BITS-1:0] tag_i,
    input  logic [OFF_BITS-1:0] rd_off_i,
    input  logic                wr_en_i,
    input  logic [OFF_BITS-1:0] wr_off_i,
    input  logic [31:0]         wdata_i,
    input  logic [3:0]          wbe_i,
    input  logic                inval_i,
    input  logic                fill_i,
    output logic                hit_o,
    output logic                valid_o,
    output logic [31:0]         rdata_o
);

    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_BITS-1:0] tag_q  [NUM_SETS];
    logic [31:0]         data_q [NUM_SETS << OFF_BITS];

    assign valid_o = valid_q[idx_i];
    assign hit_o   = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
    assign rdata_o = data_q[{idx_i, rd_off_i}];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (inval_i) begin
            valid_q[idx_i] <= 1'b0;
        end else if (fill_i) begin
            valid_q[idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_i) tag_q[idx_i] <= tag_i;
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[{idx_i, wr_off_i}] <= merge_bytes(data_q[{idx_i, wr_off_i}], wdata_i, wbe_i);
        end
    end

endmodule

// File: rtl/dcache_2way.sv
// rtl/dcache_2way.sv - two-way set-associative write-through no-write-allocate data cache
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cpu_req/we/be/addr/wdata       CPU access, held stable until cpu_ready
//   cpu_rdata, cpu_ready           read data / access completes this cycle
//   mem_req/we/be/addr/wdata       word memory request, held until mem_ack
//   mem_rdata, mem_ack             memory read data / one word transferred
//   perf_hits, perf_misses         only when DCACHE_PERF_EN is defined
module dcache_2way
    import dcache_pkg::*;
#(
    parameter int NUM_SETS    = 16,
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_BITS   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [3:0]           cpu_be,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [3:0]           mem_be,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ack
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0]          perf_hits,
    output logic [31:0]          perf_misses
`endif
);

    localparam int OFF_BITS = log2c(BLOCK_WORDS);
    localparam int IDX_BITS = log2c(NUM_SETS);
    localparam int TAG_BITS = ADDR_BITS - 2 - OFF_BITS - IDX_BITS;
    localparam logic [OFF_BITS-1:0] LAST_WORD = OFF_BITS'(BLOCK_WORDS - 1);

    logic [OFF_BITS-1:0] a_off;
    logic [IDX_BITS-1:0] a_idx;
    logic [TAG_BITS-1:0] a_tag;
    logic [1:0]          unused_byte_bits;

    assign a_off            = cpu_addr[2 +: OFF_BITS];
    assign a_idx            = cpu_addr[2 + OFF_BITS +: IDX_BITS];
    assign a_tag            = cpu_addr[ADDR_BITS-1 -: TAG_BITS];
    assign unused_byte_bits = cpu_addr[1:0];

    state_e              state_q, state_d;
    logic [OFF_BITS-1:0] cnt_q, cnt_d;
    logic                victim_q, victim_d;
    logic [NUM_SETS-1:0] lru_q;

    logic                lru_we, lru_val;
    logic [1:0]          way_hit, way_valid, way_wr, way_inval, way_fill;
    logic [31:0]         way_rdata [2];
    logic [OFF_BITS-1:0] wr_off;
    logic [31:0]         wr_data;
    logic [3:0]          wr_be;
    logic                any_hit, hit_way;
    logic                hit_cnt_en, miss_cnt_en;

    assign any_hit = |way_hit;
    assign hit_way = way_hit[1];

    for (genvar w = 0; w < 2; w++) begin : g_way
        dcache_way #(
            .NUM_SETS (NUM_SETS),
            .IDX_BITS (IDX_BITS),
            .OFF_BITS (OFF_BITS),
            .TAG_BITS (TAG_BITS)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .idx_i    (a_idx),
            .tag_i    (a_tag),
            .rd_off_i (a_off),
            .wr_en_i  (way_wr[w]),
            .wr_off_i (wr_off),
            .wdata_i  (wr_data),
            .wbe_i    (wr_be),
            .inval_i  (way_inval[w]),
            .fill_i   (way_fill[w]),
            .hit_o    (way_hit[w]),
            .valid_o  (way_valid[w]),
            .rdata_o  (way_rdata[w])
        );
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        victim_d    = victim_q;
        lru_we      = 1'b0;
        lru_val     = 1'b0;
        way_wr      = '0;
        way_inval   = '0;
        way_fill    = '0;
        wr_off      = a_off;
        wr_data     = cpu_wdata;
        wr_be       = cpu_be;
        cpu_ready   = 1'b0;
        cpu_rdata   = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_be      = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        hit_cnt_en  = 1'b0;
        miss_cnt_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!cpu_req) begin
                    cpu_ready = 1'b1;
                end else if (cpu_we) begin
                    state_d = ST_WRITE;
                end else if (any_hit) begin
                    cpu_ready  = 1'b1;
                    cpu_rdata  = way_rdata[hit_way];
                    lru_we     = 1'b1;
                    lru_val    = ~hit_way;
                    hit_cnt_en = 1'b1;
                end else begin
                    // Prefer an empty way before evicting the LRU one.
                    if (!way_valid[0])      victim_d = 1'b0;
                    else if (!way_valid[1]) victim_d = 1'b1;
                    else                    victim_d = lru_q[a_idx];
                    way_inval[victim_d] = 1'b1;
                    cnt_d       = '0;
                    miss_cnt_en = 1'b1;
                    state_d     = ST_REFILL;
                end
            end
            ST_REFILL: begin
                mem_req  = 1'b1;
                mem_be   = 4'hF;
                mem_addr = {cpu_addr[ADDR_BITS-1:2+OFF_BITS], cnt_q, 2'b00};
                if (mem_ack) begin
                    way_wr[victim_q] = 1'b1;
                    wr_off  = cnt_q;
                    wr_data = mem_rdata;
                    wr_be   = 4'hF;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        way_fill[victim_q] = 1'b1;
                        lru_we  = 1'b1;
                        lru_val = ~victim_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_be    = cpu_be;
                mem_addr  = {cpu_addr[ADDR_BITS-1:2], 2'b00};
                mem_wdata = cpu_wdata;
                if (mem_ack) begin
                    cpu_ready = 1'b1;
                    // Write-through: only update the cache if the line is present.
                    if (any_hit) begin
                        way_wr[hit_way] = 1'b1;
                        lru_we  = 1'b1;
                        lru_val = ~hit_way;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            victim_q <= 1'b0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            victim_q <= victim_d;
            if (lru_we) lru_q[a_idx] <= lru_val;
        end
    end

`ifdef DCACHE_PERF_EN
    // The completion hit right after a refill belongs to the miss, not the hit count.
    logic        after_fill_q;
    logic [31:0] perf_hits_q, perf_misses_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            after_fill_q  <= 1'b0;
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
        end else begin
            after_fill_q <= (state_q == ST_REFILL) && (state_d == ST_IDLE);
            if (hit_cnt_en && !after_fill_q) perf_hits_q <= perf_hits_q + 32'd1;
            if (miss_cnt_en) perf_misses_q <= perf_misses_q + 32'd1;
        end
    end

    assign perf_hits   = perf_hits_q;
    assign perf_misses = perf_misses_q;
`endif

endmodule

// File: tb/tb_dcache_2way.sv
// tb/tb_dcache_2way.sv - self-checking bench for dcache_2way
module tb_dcache_2way;

    localparam int NS = 16;
    localparam int BW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
`ifdef DCACHE_PERF_EN
    logic [31:0] perf_hits, perf_misses;
`endif

    dcache_2way #(.NUM_SETS(NS), .BLOCK_WORDS(BW), .ADDR_BITS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_be    (cpu_be),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef DCACHE_PERF_EN
        ,
        .perf_hits   (perf_hits),
        .perf_misses (perf_misses)
`endif
    );

    always #5 clk = ~clk;

    // Memory device (driven by the DUT bus) and the bench's own reference image.
    logic [31:0] tbmem  [1024];
    logic [31:0] refmem [1024];
    logic        ack_ok   = 1'b1;
    logic        ack_rand = 1'b0;

    assign mem_ack   = ack_ok;
    assign mem_rdata = tbmem[mem_addr[11:2]];

    always @(negedge clk) ack_ok = ack_rand ? ($urandom_range(0, 2) != 0) : 1'b1;

    always @(posedge clk) begin
        if (mem_req && mem_we && mem_ack) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) tbmem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference: per set, resident tags ordered most- to least-recently used.
    int unsigned sets_q [NS][$];
    int          m_hits, m_misses;
    int          checks, errors;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic model_touch(input int unsigned a, input bit alloc, output bit found);
        int s;
        int unsigned t;
        s = int'((a >> 4) % NS);
        t = a >> 8;
        found = 1'b0;
        for (int i = 0; i < sets_q[s].size(); i++) begin
            if (!found && sets_q[s][i] == t) begin
                found = 1'b1;
                sets_q[s].delete(i);
                sets_q[s].push_front(t);
            end
        end
        if (!found && alloc) begin
            sets_q[s].push_front(t);
            if (sets_q[s].size() > 2) void'(sets_q[s].pop_back());
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) sets_q[s].delete();
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic do_read(input logic [31:0] a, input bit exact, output logic [31:0] data,
                           output bit was_hit);
        bit          exp_hit, done;
        logic [31:0] exp_d;
        logic [31:0] addrs[$];
        int          waits, nwr;
        exp_d = refmem[a[11:2]];
        model_touch(a, 1'b1, exp_hit);
        if (exp_hit) m_hits++; else m_misses++;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        cpu_be = 4'($urandom); cpu_wdata = $urandom;
        waits = 0; done = 1'b0; nwr = 0; data = '0;
        while (!done && waits < 200) begin
            #1;
            if (mem_req && mem_ack) begin
                addrs.push_back(mem_addr);
                if (mem_we) nwr++;
            end
            if (cpu_ready) begin
                done = 1'b1;
                data = cpu_rdata;
            end else begin
                @(negedge clk);
                waits++;
            end
        end
        was_hit = (waits == 0) && (addrs.size() == 0);
        chk("rd_done", 32'(done), 32'd1);
        chk("rd_data", data, exp_d);
        chk("rd_hit", 32'(was_hit), 32'(exp_hit));
        chk("rd_memwrites", 32'(nwr), 32'd0);
        if (!exp_hit) begin
            chk("rd_acks", 32'(addrs.size()), 32'(BW));
            for (int k = 0; k < addrs.size(); k++)
                chk("rd_addr", addrs[k], (a & ~32'hF) + 32'(4 * k));
            if (exact) chk("rd_latency", 32'(waits), 32'(BW + 1));
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                            input bit exact);
        bit          found, done;
        int          waits, nack;
        logic        c_we, ack_at_ready;
        logic [3:0]  c_be;
        logic [31:0] c_addr, c_wd;
        for (int b = 0; b < 4; b++)
            if (be[b]) refmem[a[11:2]][8*b +: 8] = d[8*b +: 8];
        model_touch(a, 1'b0, found);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_be = be; cpu_wdata = d;
        waits = 0; done = 1'b0; nack = 0; ack_at_ready = 1'b0;
        c_we = 1'b0; c_be = '0; c_addr = '0; c_wd = '0;
        while (!done && waits < 200) begin
            #1;
            if (mem_req && mem_ack) begin
                nack++;
                c_we = mem_we; c_be = mem_be; c_addr = mem_addr; c_wd = mem_wdata;
            end
            if (cpu_ready) begin
                done = 1'b1;
                ack_at_ready = mem_req && mem_ack;
            end else begin
                @(negedge clk);
                waits++;
            end
        end
        chk("wr_done", 32'(done), 32'd1);
        chk("wr_ready_with_ack", 32'(ack_at_ready), 32'd1);
        chk("wr_acks", 32'(nack), 32'd1);
        chk("wr_we", 32'(c_we), 32'd1);
        chk("wr_be", 32'(c_be), 32'(be));
        chk("wr_addr", c_addr, a & ~32'h3);
        chk("wr_wdata", c_wd, d);
        if (exact) chk("wr_latency", 32'(waits), 32'd1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] d;
        bit          h;
        int          nack;
        checks = 0; errors = 0;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = '0; cpu_addr = '0; cpu_wdata = '0;
        for (int i = 0; i < 1024; i++) begin
            tbmem[i]  = $urandom;
            refmem[i] = tbmem[i];
        end
        tbmem[32'h108 >> 2]  = 32'h11223344;
        refmem[32'h108 >> 2] = 32'h11223344;
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd1);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
`ifdef DCACHE_PERF_EN
        chk("rst_perf_hits", perf_hits, 32'd0);
        chk("rst_perf_misses", perf_misses, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // 1, 2: cold miss then hit in the same line
        do_read(32'h100, 1'b1, d, h);
        chk("s1_miss", 32'(h), 32'd0);
`ifdef DCACHE_PERF_EN
        chk("s1_perf_misses", perf_misses, 32'd1);
`endif
        do_read(32'h104, 1'b1, d, h);
        chk("s2_hit", 32'(h), 32'd1);
`ifdef DCACHE_PERF_EN
        chk("s2_perf_hits", perf_hits, 32'd1);
`endif

        // 3: conflict eviction on index 0
        do_read(32'h200, 1'b1, d, h);
        chk("s3_200_miss", 32'(h), 32'd0);
        do_read(32'h100, 1'b1, d, h);
        chk("s3_100_hit", 32'(h), 32'd1);
        do_read(32'h300, 1'b1, d, h);
        chk("s3_300_miss", 32'(h), 32'd0);
        do_read(32'h100, 1'b1, d, h);
        chk("s3_100_rehit", 32'(h), 32'd1);
        do_read(32'h200, 1'b1, d, h);
        chk("s3_200_evicted", 32'(h), 32'd0);

        // 4: partial write hit merges into the cached word
        do_write(32'h108, 32'hDEADBEEF, 4'b0011, 1'b1);
        do_read(32'h108, 1'b1, d, h);
        chk("s4_merge_data", d, 32'h1122BEEF);
        chk("s4_hit", 32'(h), 32'd1);

        // 5: write miss does not allocate
        do_write(32'h400, 32'hCAFEF00D, 4'hF, 1'b1);
        do_read(32'h400, 1'b1, d, h);
        chk("s5_no_allocate", 32'(h), 32'd0);
        chk("s5_data", d, 32'hCAFEF00D);

        // 6: reset on the third ack of a refill
        pulse_reset();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        nack = 0;
        for (int c = 0; c < 50 && nack < 3; c++) begin
            #1;
            if (mem_req && mem_ack) nack++;
            if (nack == 3) begin
                rst = 1'b1;
                cpu_req = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        chk("s6_third_ack", 32'(nack), 32'd3);
        @(posedge clk); #1;
        chk("s6_req_dropped", 32'(mem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        do_read(32'h100, 1'b1, d, h);
        chk("s6_refill_again", 32'(h), 32'd0);

        // Randomised traffic with a stalling memory, few tags on two sets.
        ack_rand = 1'b1;
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 1)) << 4)
              | (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 9) < 7) do_read(a, 1'b0, d, h);
            else do_write(a, $urandom, 4'($urandom_range(1, 15)), 1'b0);
        end
`ifdef DCACHE_PERF_EN
        chk("end_perf_hits", perf_hits, 32'(m_hits));
        chk("end_perf_misses", perf_misses, 32'(m_misses));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
